// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Two-stage instruction fetch front end feeding an in-order fetch queue.
//   F1 issues a word fetch from the pc register; F2 receives the instruction
//   one cycle later, asks the branch predictor about it and enqueues it.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req_o/imem_addr_o  fetch request and word address to instruction memory
//   imem_rdata_i            instruction word for the previous cycle's request
//   bp_pc_o/bp_pc_plus4_o/bp_instr_o  F2 instruction presented to the predictor
//   bp_valid_i/bp_taken_i/bp_target_i combinational prediction for bp_pc_o
//   redirect_valid_i/redirect_pc_i    back-end redirect (mispredict/exception)
//   fq_valid_o/fq_ready_i   valid-ready handshake towards decode
//   fq_pc_o/fq_instr_o/fq_pred_taken_o/fq_pred_target_o  head queue entry
// ---------------------------------------------------------------------------

// Checker: an enqueue into a full queue means the issue credit rule broke.
module instr_fetch_unit_chk (
    input logic clk,
    input logic rst_n,
    input logic enq_i,
    input logic full_i
);
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq_i && full_i));
endmodule

module instr_fetch_unit #(
    parameter int unsigned                 ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = {ADDR_WIDTH{1'b0}},
    parameter int unsigned                 FQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction memory
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]           imem_rdata_i,
    // branch predictor
    output logic [ADDR_WIDTH-1:0] bp_pc_o,
    output logic [ADDR_WIDTH-1:0] bp_pc_plus4_o,
    output logic [31:0]           bp_instr_o,
    input  logic                  bp_valid_i,
    input  logic                  bp_taken_i,
    input  logic [ADDR_WIDTH-1:0] bp_target_i,
    // back-end redirect
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    // fetch queue towards decode
    output logic                  fq_valid_o,
    input  logic                  fq_ready_i,
    output logic [ADDR_WIDTH-1:0] fq_pc_o,
    output logic [31:0]           fq_instr_o,
    output logic                  fq_pred_taken_o,
    output logic [ADDR_WIDTH-1:0] fq_pred_target_o
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(FQ_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE_C  = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE_C  = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] FOUR_C     = ADDR_WIDTH'(4);
    // Clears the two byte-offset bits so pc always holds a word address.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

    // F1/F2 pipeline state
    logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
    logic                  f2_valid_q, f2_valid_d;
    logic [ADDR_WIDTH-1:0] f2_pc_q,    f2_pc_d;

    // queue control state
    logic [CNT_W-1:0]      fq_count_q, fq_count_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;

    // queue storage (contents only meaningful between rd_ptr and wr_ptr)
    logic [ADDR_WIDTH-1:0] mem_pc_q     [FQ_DEPTH];
    logic [31:0]           mem_instr_q  [FQ_DEPTH];
    logic                  mem_taken_q  [FQ_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_target_q [FQ_DEPTH];

    logic                  pred_taken_s;
    logic                  issue_s;
    logic                  enq_s;
    logic                  deq_s;
    logic                  fq_full_s;
    logic [ADDR_WIDTH-1:0] f2_pc_plus4_s;
    logic [ADDR_WIDTH-1:0] enq_target_s;

    // Issue credit, prediction qualification and queue handshakes.
    always_comb begin
        f2_pc_plus4_s = f2_pc_q + FOUR_C;
        pred_taken_s  = f2_valid_q && bp_valid_i && bp_taken_i;
        // Counting the F2 slot as already occupied guarantees room for it.
        issue_s       = !redirect_valid_i &&
                        ((fq_count_q + CNT_W'(f2_valid_q)) < DEPTH_C);
        enq_s         = f2_valid_q && !redirect_valid_i;
        deq_s         = (fq_count_q != '0) && fq_ready_i && !redirect_valid_i;
        fq_full_s     = (fq_count_q == DEPTH_C);
        if (pred_taken_s) begin
            enq_target_s = bp_target_i;
        end else begin
            enq_target_s = f2_pc_plus4_s;
        end
    end

    // Next pc and F2 stage: redirect beats predicted-taken beats sequential.
    always_comb begin
        pc_d       = pc_q;
        f2_pc_d    = f2_pc_q;
        f2_valid_d = 1'b0;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i & ALIGN_MASK;
        end else if (pred_taken_s) begin
            pc_d = bp_target_i & ALIGN_MASK;
        end else if (issue_s) begin
            pc_d = pc_q + FOUR_C;
        end else begin
            pc_d = pc_q;
        end
        if (issue_s) begin
            f2_pc_d    = pc_q;
            // The fetch issued alongside a taken F2 is on the wrong path.
            f2_valid_d = !pred_taken_s;
        end else begin
            f2_pc_d    = f2_pc_q;
            f2_valid_d = 1'b0;
        end
    end

    // Queue pointer and occupancy next state; a redirect flushes everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fq_count_d = fq_count_q;
        if (redirect_valid_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fq_count_d = '0;
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE_C;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   fq_count_d = fq_count_q + CNT_ONE_C;
                2'b01:   fq_count_d = fq_count_q - CNT_ONE_C;
                default: fq_count_d = fq_count_q;
            endcase
        end
    end

    // Pipeline and queue control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            f2_valid_q <= 1'b0;
            f2_pc_q    <= '0;
            fq_count_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            f2_valid_q <= f2_valid_d;
            f2_pc_q    <= f2_pc_d;
            fq_count_q <= fq_count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage write; no reset needed since occupancy gates the outputs.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_pc_q[wr_ptr_q]     <= f2_pc_q;
            mem_instr_q[wr_ptr_q]  <= imem_rdata_i;
            mem_taken_q[wr_ptr_q]  <= pred_taken_s;
            mem_target_q[wr_ptr_q] <= enq_target_s;
        end
    end

    // Output drive: head entry is forced to zero while the queue is empty.
    always_comb begin
        // Request is held low while reset is applied.
        imem_req_o    = issue_s && rst_n;
        imem_addr_o   = pc_q;
        bp_pc_o       = f2_pc_q;
        bp_pc_plus4_o = f2_pc_plus4_s;
        bp_instr_o    = imem_rdata_i;
        fq_valid_o    = (fq_count_q != '0);
        if (fq_count_q != '0) begin
            fq_pc_o          = mem_pc_q[rd_ptr_q];
            fq_instr_o       = mem_instr_q[rd_ptr_q];
            fq_pred_taken_o  = mem_taken_q[rd_ptr_q];
            fq_pred_target_o = mem_target_q[rd_ptr_q];
        end else begin
            fq_pc_o          = '0;
            fq_instr_o       = 32'h0000_0000;
            fq_pred_taken_o  = 1'b0;
            fq_pred_target_o = '0;
        end
    end

    instr_fetch_unit_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .enq_i  (enq_s),
        .full_i (fq_full_s)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic [31:0] bp_pc;
    logic [31:0] bp_pc_plus4;
    logic [31:0] bp_instr;
    logic        bp_valid = 1'b0;
    logic        bp_taken = 1'b0;
    logic [31:0] bp_target = 32'h0000_0000;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic        fq_valid;
    logic        fq_ready = 1'b0;
    logic [31:0] fq_pc;
    logic [31:0] fq_instr;
    logic        fq_pred_taken;
    logic [31:0] fq_pred_target;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0100),
        .FQ_DEPTH   (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .bp_pc_o          (bp_pc),
        .bp_pc_plus4_o    (bp_pc_plus4),
        .bp_instr_o       (bp_instr),
        .bp_valid_i       (bp_valid),
        .bp_taken_i       (bp_taken),
        .bp_target_i      (bp_target),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .fq_valid_o       (fq_valid),
        .fq_ready_i       (fq_ready),
        .fq_pc_o          (fq_pc),
        .fq_instr_o       (fq_instr),
        .fq_pred_taken_o  (fq_pred_taken),
        .fq_pred_target_o (fq_pred_target)
    );

    always #5 clk = ~clk;

    // Instruction word stored at each address of the memory model.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: data returns the cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= instr_of(imem_addr);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0000_0000;
        bp_valid = 1'b0;
        bp_taken = 1'b0;
        bp_target = 32'h0000_0000;
        fq_ready = ready;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        repeat (2) begin
            n_checks++;
            if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
            n_checks++;
            if (fq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fq_valid got %b exp 0", fq_valid); end
            n_checks++;
            if ({fq_pc, fq_instr, fq_pred_target, fq_pred_taken} !== 97'd0) begin
                n_fail++; $display("FAIL reset_head got %h/%h/%h/%b exp zeros", fq_pc, fq_instr, fq_pred_target, fq_pred_taken);
            end
            n_checks++;
            if (imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_addr got %h exp 00000100", imem_addr); end
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL first_req got %b/%h exp 1/00000100", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            e = 32'h0000_0100 + 32'(4 * i);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== e) begin
                n_fail++; $display("FAIL seq_fetch[%0d] got %b/%h exp 1/%h", i, imem_req, imem_addr, e);
            end
            if (i >= 2) begin
                e = 32'h0000_0100 + 32'(4 * (i - 2));
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== e || fq_instr !== instr_of(e) ||
                    fq_pred_taken !== 1'b0 || fq_pred_target !== e + 32'd4) begin
                    n_fail++; $display("FAIL seq_entry[%0d] got %b/%h/%h/%b/%h exp 1/%h/%h/0/%h",
                        i, fq_valid, fq_pc, fq_instr, fq_pred_taken, fq_pred_target, e, instr_of(e), e + 32'd4);
                end
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        repeat (5) step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (fq_valid !== 1'b0 || imem_req !== 1'b0 || fq_pc !== 32'h0) begin
            n_fail++; $display("FAIL async_reset got %b/%b/%h exp 0/0/0", fq_valid, imem_req, fq_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL async_restart got %b/%h exp 1/00000100", imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (fq_valid !== 1'b0) begin n_fail++; $display("FAIL async_no_stale got %b exp 0", fq_valid); end
        step();
        n_checks++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h0000_0100) begin
            n_fail++; $display("FAIL async_first_entry got %b/%h exp 1/00000100", fq_valid, fq_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (imem_req !== (i <= 3)) begin n_fail++; $display("FAIL bp_req[%0d] got %b exp %b", i, imem_req, (i <= 3)); end
            if (i >= 2) begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== 32'h100 || fq_instr !== instr_of(32'h100) ||
                    fq_pred_target !== 32'h104) begin
                    n_fail++; $display("FAIL bp_hold[%0d] got %b/%h/%h/%h exp 1/00000100/%h/00000104",
                        i, fq_valid, fq_pc, fq_instr, fq_pred_target, instr_of(32'h100));
                end
            end
            step();
        end
        fq_ready = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req got %b exp 0", imem_req); end
        e = 32'h0000_0100;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0110) begin
                    n_fail++; $display("FAIL bp_resume got %b/%h exp 1/00000110", imem_req, imem_addr);
                end
            end
            if (fq_valid === 1'b1) begin
                n_checks++;
                if (fq_pc !== e) begin n_fail++; $display("FAIL bp_order[%0d] got %h exp %h", k, fq_pc, e); end
                e = e + 32'd4;
            end
            step();
        end
        n_checks++;
        if (e !== 32'h0000_0130) begin n_fail++; $display("FAIL bp_drain_count got %h exp 00000130", e); end
    endtask

    task automatic test_predict();
        logic [31:0] exp_pc [6];
        logic [31:0] got_pc [6];
        logic [31:0] got_tg [6];
        logic        got_tk [6];
        int k;
        exp_pc = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208};
        k = 0;
        do_reset(1'b1);
        for (int c = 0; c < 14; c++) begin
            if (bp_pc === 32'h0000_0108) begin
                bp_valid = 1'b1; bp_taken = 1'b1; bp_target = 32'h0000_0200;
            end else begin
                bp_valid = 1'b0; bp_taken = 1'b0; bp_target = 32'h0000_0000;
            end
            #1;
            if (fq_valid === 1'b1 && k < 6) begin
                got_pc[k] = fq_pc; got_tk[k] = fq_pred_taken; got_tg[k] = fq_pred_target;
                k++;
            end
            step();
        end
        bp_valid = 1'b0; bp_taken = 1'b0; bp_target = 32'h0000_0000;
        n_checks++;
        if (k != 6) begin n_fail++; $display("FAIL pred_entries got %0d exp 6", k); end
        for (int j = 0; j < k; j++) begin
            n_checks++;
            if (got_pc[j] !== exp_pc[j] || got_tk[j] !== (j == 2) ||
                got_tg[j] !== ((j == 2) ? 32'h200 : exp_pc[j] + 32'd4)) begin
                n_fail++; $display("FAIL pred_entry[%0d] got %h/%b/%h exp %h/%b/%h", j, got_pc[j], got_tk[j], got_tg[j],
                    exp_pc[j], (j == 2), (j == 2) ? 32'h200 : exp_pc[j] + 32'd4);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (4) step();
        n_checks++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h100) begin
            n_fail++; $display("FAIL redir_pre got %b/%h exp 1/00000100", fq_valid, fq_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0402;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req got %b exp 0", imem_req); end
        step();
        redirect_valid = 1'b0;
        redirect_pc = 32'h0000_0000;
        #1;
        n_checks++;
        if (fq_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0400) begin
            n_fail++; $display("FAIL redir_next got %b/%b/%h exp 0/1/00000400", fq_valid, imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (fq_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap got %b exp 0", fq_valid); end
        step();
        n_checks++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h400 || fq_instr !== instr_of(32'h400) || fq_pred_target !== 32'h404) begin
            n_fail++; $display("FAIL redir_entry got %b/%h/%h/%h exp 1/00000400/%h/00000404",
                fq_valid, fq_pc, fq_instr, fq_pred_target, instr_of(32'h400));
        end
    endtask

    task automatic test_redirect_vs_predict();
        do_reset(1'b1);
        repeat (3) step();
        n_checks++;
        if (bp_pc !== 32'h0000_0108 || bp_pc_plus4 !== 32'h0000_010C || bp_instr !== instr_of(32'h108)) begin
            n_fail++; $display("FAIL rvp_f2 got %h/%h/%h exp 00000108/0000010c/%h", bp_pc, bp_pc_plus4, bp_instr, instr_of(32'h108));
        end
        bp_valid = 1'b1; bp_taken = 1'b1; bp_target = 32'h0000_0200;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        bp_valid = 1'b0; bp_taken = 1'b0; bp_target = 32'h0000_0000;
        redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
        #1;
        n_checks++;
        if (imem_addr !== 32'h0000_0300 || fq_valid !== 1'b0) begin
            n_fail++; $display("FAIL rvp_pc got %h/%b exp 00000300/0", imem_addr, fq_valid);
        end
        repeat (2) step();
        n_checks++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h300 || fq_pred_taken !== 1'b0 || fq_pred_target !== 32'h304) begin
            n_fail++; $display("FAIL rvp_entry got %b/%h/%b/%h exp 1/00000300/0/00000304",
                fq_valid, fq_pc, fq_pred_taken, fq_pred_target);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [31:0] e;
        do_reset(1'b0);
        repeat (3) step();
        fq_ready = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            e = 32'h0000_0100 + 32'(4 * k);
            n_checks++;
            if (fq_valid !== 1'b1 || fq_pc !== e || fq_instr !== instr_of(e) ||
                imem_req !== 1'b1 || imem_addr !== e + 32'h0000_000C) begin
                n_fail++; $display("FAIL wrap[%0d] got %b/%h/%h/%b/%h exp 1/%h/%h/1/%h", k, fq_valid, fq_pc, fq_instr,
                    imem_req, imem_addr, e, instr_of(e), e + 32'h0000_000C);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_async_reset();
        test_backpressure();
        test_predict();
        test_redirect();
        test_redirect_vs_predict();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
